// File: rtl/ahblite_waterlight.sv
// AHB-Lite slave driving an 8-bit LED "water light" (rotate left/right, flash, off).
// Define WATERLIGHT_LEDREAD_EN to make the LED state readable at offset 2 (0x40000008).
module ahblite_waterlight #(
  parameter logic [31:0] SPEED_RST = 32'd5_000_000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [7:0]  LED
);

  typedef enum logic [7:0] {
    MODE_OFF   = 8'd0,
    MODE_ROTL  = 8'd1,
    MODE_ROTR  = 8'd2,
    MODE_FLASH = 8'd3
  } mode_e;

  logic        accept;
  logic        dp_valid;
  logic        dp_write;
  logic [1:0]  dp_addr;
  logic        wr_mode;
  logic        wr_speed;
  logic        mode_change;
  logic [7:0]  mode;
  logic [31:0] speed;
  logic [31:0] count;
  logic        tick;
  logic [7:0]  led_q;
  logic [7:0]  led_d;
  logic        unused_bits;

  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= HWRITE;
        dp_addr  <= HADDR[3:2];
      end
    end
  end

  assign wr_mode     = dp_valid & dp_write & (dp_addr == 2'd0);
  assign wr_speed    = dp_valid & dp_write & (dp_addr == 2'd1);
  assign mode_change = wr_mode & (HWDATA[7:0] != mode);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mode  <= MODE_OFF;
      speed <= SPEED_RST;
    end else begin
      if (wr_mode)  mode  <= HWDATA[7:0];
      if (wr_speed) speed <= HWDATA;
    end
  end

  // >= (not ==) so a SPEED lowered below the running count ticks at once instead of wrapping.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (mode_change) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count >= speed) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 32'd1;
      tick  <= 1'b0;
    end
  end

  function automatic logic [7:0] seed_of(input logic [7:0] m);
    case (m)
      MODE_ROTL:  seed_of = 8'h01;
      MODE_ROTR:  seed_of = 8'h80;
      MODE_FLASH: seed_of = 8'hFF;
      default:    seed_of = 8'h00;
    endcase
  endfunction

  always_ff @(posedge HCLK) begin
    if (HRESET) led_q <= '0;
    else        led_q <= led_d;
  end

  // A changing MODE write reseeds and wins over a coincident tick.
  always_comb begin
    led_d = led_q;
    if (mode_change) begin
      led_d = seed_of(HWDATA[7:0]);
    end else if (tick) begin
      case (mode)
        MODE_ROTL:  led_d = {led_q[6:0], led_q[7]};
        MODE_ROTR:  led_d = {led_q[0], led_q[7:1]};
        MODE_FLASH: led_d = ~led_q;
        default:    led_d = '0;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (!HRESET) begin
      case (dp_addr)
        2'd0:    HRDATA = {24'b0, mode};
        2'd1:    HRDATA = speed;
`ifdef WATERLIGHT_LEDREAD_EN
        2'd2:    HRDATA = {24'b0, led_q};
`endif
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign LED       = led_q;

endmodule

// File: tb/tb_ahblite_waterlight.sv
// Self-checking bench for ahblite_waterlight: register table, directed corner sequences,
// then randomized bus traffic against a cycle-level reference model.
module tb_ahblite_waterlight;

  localparam logic [31:0] SPD_RST = 32'd20;
  localparam logic [31:0] BASE    = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic [7:0]  led;

  ahblite_waterlight #(.SPEED_RST(SPD_RST)) dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp), .LED(led)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Reference model state
  logic [7:0]  m_mode, m_led;
  logic [31:0] m_speed, m_cnt;
  bit          m_tick, m_dv, m_dw;
  logic [1:0]  m_da;

  typedef struct {
    bit          wr;
    logic [3:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", phase, name, act, exp);
    end
  endtask

  function automatic logic [7:0] seed(input logic [7:0] m);
    if (m == 8'd1) return 8'h01;
    if (m == 8'd2) return 8'h80;
    if (m == 8'd3) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] m, input logic [7:0] l);
    if (m == 8'd1) return (l == 8'h80) ? 8'h01 : 8'(l * 2);
    if (m == 8'd2) return (l == 8'h01) ? 8'h80 : 8'(l / 2);
    if (m == 8'd3) return 8'(8'hFF - l);
    return 8'h00;
  endfunction

  task automatic model_edge();
    bit wr, chg;
    if (rst) begin
      m_mode = 0; m_speed = SPD_RST; m_cnt = 0; m_tick = 0; m_led = 0;
      m_dv = 0; m_dw = 0; m_da = 0;
      return;
    end
    wr  = m_dv && m_dw;
    chg = wr && (m_da == 2'd0) && (hwdata[7:0] != m_mode);
    if (chg) begin
      m_led = seed(hwdata[7:0]); m_cnt = 0; m_tick = 0;
    end else begin
      if (m_tick) m_led = step(m_mode, m_led);
      if (m_cnt >= m_speed) begin m_cnt = 0; m_tick = 1; end
      else begin m_cnt = m_cnt + 1; m_tick = 0; end
    end
    if (wr && m_da == 2'd0) m_mode  = hwdata[7:0];
    if (wr && m_da == 2'd1) m_speed = hwdata;
    m_dv = hsel && hready && htrans[1];
    if (m_dv) begin m_dw = hwrite; m_da = haddr[3:2]; end
  endtask

  function automatic logic [31:0] exp_rdata();
    if (rst) return 32'h0;
    case (m_da)
      2'd0: return {24'b0, m_mode};
      2'd1: return m_speed;
`ifdef WATERLIGHT_LEDREAD_EN
      2'd2: return {24'b0, m_led};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", {24'b0, led}, {24'b0, m_led});
    chk("hrdata", hrdata, exp_rdata());
    chk("ready_resp", {30'b0, hreadyout, hresp}, 32'h2);
  endtask

  task automatic idle();
    hsel = 0; htrans = 2'b00; hwrite = 0; haddr = '0;
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] a);
    hsel = 1; htrans = 2'b10; hwrite = wr; haddr = a;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    addr_phase(1, a); cycle();
    idle(); hwdata = d; cycle();
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr_phase(0, a); cycle();
    d = hrdata;
    idle(); cycle();
  endtask

  task automatic wait_led_change(output int n);
    logic [7:0] prev;
    prev = led;
    n = 0;
    do begin cycle(); n++; end while (led == prev && n < 40);
    if (led == prev) chk("led_change_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          n;
    logic [7:0]  prev;
    logic [7:0]  rot_exp [8];
    vec_t        vecs [12];

    rot_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    vecs = '{
      '{0, 4'h0, 32'h0,        32'h0},
      '{0, 4'h4, 32'h0,        SPD_RST},
      '{0, 4'hC, 32'h0,        32'h0},
      '{1, 4'h4, 32'h12345678, 32'h0},
      '{0, 4'h4, 32'h0,        32'h12345678},
      '{1, 4'h8, 32'hDEAD,     32'h0},
      '{0, 4'h8, 32'h0,        32'h0},
      '{1, 4'hC, 32'h5,        32'h0},
      '{0, 4'hC, 32'h0,        32'h0},
      '{1, 4'h0, 32'h1FF,      32'h0},
      '{0, 4'h0, 32'h0,        32'hFF},
      '{1, 4'h0, 32'h0,        32'h0}
    };

    rst = 1; hready = 1; hsize = 3'b010; hprot = 4'b0011; hwdata = '0;
    idle();

    phase = "reset";
    repeat (3) cycle();
    chk("rdata_in_reset", hrdata, 32'h0);
    chk("led_in_reset", {24'b0, led}, 32'h0);
    rst = 0;

    phase = "table";
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) write_reg(BASE | 32'(vecs[i].off), vecs[i].data);
      else begin
        read_reg(BASE | 32'(vecs[i].off), rd);
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    phase = "rotate";
    write_reg(BASE + 4, 32'd3);
    write_reg(BASE, 32'd1);
    chk("seed_rotl", {24'b0, led}, 32'h01);
    for (int i = 0; i < 8; i++) begin
      wait_led_change(n);
      chk($sformatf("rot%0d", i), {24'b0, led}, {24'b0, rot_exp[i]});
      if (i > 0) chk($sformatf("rot_period%0d", i), 32'(n), 32'd4);
    end

    phase = "flash";
    write_reg(BASE, 32'd2);
    chk("seed_rotr", {24'b0, led}, 32'h80);
    write_reg(BASE, 32'd3);
    chk("seed_flash", {24'b0, led}, 32'hFF);
    write_reg(BASE + 4, 32'd0);
    repeat (2) cycle();
    for (int i = 0; i < 6; i++) begin
      prev = led;
      cycle();
      chk($sformatf("flash_toggle%0d", i), {24'b0, led}, {24'b0, ~prev});
    end
    write_reg(BASE, 32'd3);
    repeat (4) cycle();

    phase = "order_gate";
    addr_phase(1, BASE + 4); cycle();
    addr_phase(0, BASE + 4); hwdata = 32'h12345678; cycle();
    chk("b2b_read", hrdata, 32'h12345678);
    idle(); cycle();
    hsel = 1; htrans = 2'b00; hwrite = 1; haddr = BASE + 4; cycle();
    idle(); hwdata = 32'h55; cycle();
    hsel = 0; htrans = 2'b10; hwrite = 1; haddr = BASE + 4; cycle();
    idle(); hwdata = 32'h66; cycle();
    read_reg(BASE + 4, rd);
    chk("gated_write", rd, 32'h12345678);

    phase = "speed_drop";
    write_reg(BASE + 4, 32'd1000);
    write_reg(BASE, 32'd2);
    repeat (96) cycle();
    write_reg(BASE + 4, 32'd10);
    wait_led_change(n);
    chk("drop_first", 32'(n), 32'd2);
    wait_led_change(n);
    chk("drop_period_a", 32'(n), 32'd11);
    wait_led_change(n);
    chk("drop_period_b", 32'(n), 32'd11);

    phase = "ledread";
    write_reg(BASE, 32'd1);
    read_reg(BASE + 8, rd);
`ifdef WATERLIGHT_LEDREAD_EN
    chk("led_readback", rd, 32'h01);
`else
    chk("led_readback", rd, 32'h0);
`endif

    phase = "reset_mid";
    addr_phase(1, BASE); cycle();
    idle(); hwdata = 32'd3; rst = 1; cycle();
    rst = 0;
    read_reg(BASE, rd);
    chk("mode_after_reset", rd, 32'h0);
    read_reg(BASE + 4, rd);
    chk("speed_after_reset", rd, SPD_RST);
    chk("led_after_reset", {24'b0, led}, 32'h0);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      hsel   = ($urandom % 4) != 0;
      htrans = 2'($urandom % 4);
      hwrite = 1'($urandom % 2);
      haddr  = BASE | 32'(($urandom % 4) << 2) | 32'($urandom % 4);
      hsize  = 3'($urandom % 8);
      hprot  = 4'($urandom % 16);
      hready = ($urandom % 8) != 0;
      hwdata = (($urandom % 8) == 0) ? $urandom : $urandom_range(0, 6);
      rst    = ($urandom % 150) == 0;
      cycle();
    end
    rst = 0; hready = 1; idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
